// File: rtl/arb_pkg.sv
// Shared types and one-hot helpers for the arbiter request-queue front-end.
package arb_pkg;

  localparam int unsigned NUM_REQS_DEF = 4;
  localparam int unsigned VEC_MAX      = 32;

  typedef logic [NUM_REQS_DEF-1:0] req_vec_t;

  // True when at most one bit is set; callers zero-extend narrower vectors.
  function automatic logic onehot_chk(input logic [VEC_MAX-1:0] v);
    return (v & (v - 1'b1)) == '0;
  endfunction

  function automatic logic [4:0] onehot_enc(input logic [VEC_MAX-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < VEC_MAX; i++) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Single-requestor circular buffer; pointers carry one extra wrap bit.
module arb_req_fifo
  import arb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/arb_req_queue.sv
// Per-requestor queues feeding random_arbiter; grant pops onto one tagged channel.
// Optional starvation monitor: define ARB_REQ_QUEUE_STARVE_MON_EN.
module arb_req_queue
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQS = NUM_REQS_DEF,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned STARVE_K = 50
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQS-1:0]          in_valid,
  output logic [NUM_REQS-1:0]          in_ready,
  input  logic [NUM_REQS*DATA_W-1:0]   in_data,
  output logic [NUM_REQS-1:0]          req,
  input  logic [NUM_REQS-1:0]          grant,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(NUM_REQS)-1:0]  out_src,
  output logic                         grant_err,
  output logic [NUM_REQS-1:0]          starve
);

  localparam int unsigned SW = $clog2(NUM_REQS);

  logic [NUM_REQS-1:0] w_full;
  logic [NUM_REQS-1:0] w_empty;
  logic [NUM_REQS-1:0] w_pop;
  logic [DATA_W-1:0]   w_head [NUM_REQS];
  logic [VEC_MAX-1:0]  w_grant_ext;
  logic                w_multi;
  logic                w_hit;
  logic                w_g_ok;
  logic [SW-1:0]       w_src;
  logic                r_grant_err;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_q
    arb_req_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (in_valid[i]),
      .i_data  (in_data[i*DATA_W +: DATA_W]),
      .i_pop   (w_pop[i]),
      .o_full  (w_full[i]),
      .o_empty (w_empty[i]),
      .o_head  (w_head[i])
    );
    assign w_pop[i] = w_g_ok && out_ready && (w_src == SW'(i));
  end

  assign in_ready = ~w_full;
  assign req      = ~w_empty;

  // A legal grant is exactly one bit, aimed at a queue that currently requests.
  assign w_grant_ext = VEC_MAX'(grant);
  assign w_multi     = !onehot_chk(w_grant_ext);
  assign w_hit       = (|grant) && !w_multi;
  assign w_src       = SW'(onehot_enc(w_grant_ext));
  assign w_g_ok      = w_hit && req[w_src];

  assign out_valid = w_g_ok;
  assign out_src   = w_src;
  assign out_data  = w_head[w_src];
  assign grant_err = r_grant_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_err <= 1'b0;
    end else if (w_multi || (w_hit && !req[w_src])) begin
      r_grant_err <= 1'b1;
    end
  end

`ifdef ARB_REQ_QUEUE_STARVE_MON_EN
  localparam logic [7:0] STARVE_K8 = 8'(STARVE_K);

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_mon
    logic [7:0] r_wait;
    logic [7:0] w_wait_nxt;
    logic       r_starve;

    always_comb begin
      w_wait_nxt = r_wait;
      if (w_pop[i])                    w_wait_nxt = '0;
      else if (req[i] && r_wait != '1) w_wait_nxt = r_wait + 1'b1;
    end

    // Level is taken from the next count so a pop clears it one cycle later.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_wait   <= '0;
        r_starve <= 1'b0;
      end else begin
        r_wait   <= w_wait_nxt;
        r_starve <= (w_wait_nxt >= STARVE_K8);
      end
    end

    assign starve[i] = r_starve;
  end
`else
  assign starve = '0;
`endif

endmodule
